scarv_cop_palu_dispatch: RTL and testbench
==========================================

Name: scarv_cop_palu_dispatch

Overview:
- Issue and writeback controller that drives the packed ALU's ivalid/idone handshake from the decode side; it is the initiator for which the PALU is the responder.
- Accepts one decoded coprocessor instruction per transaction via valid/ready.
- Reads CPR operands and holds them stable to the PALU until it signals done.
- Commits the byte-enabled result to the CPR file and pulses completion back to the CPU interface.

Parameters:
- TIMEOUT_CYCLES, 64, max EXEC cycles before the watchdog fires (only with SCARV_COP_DISPATCH_WDOG_EN).
- CTR_W, 7, watchdog counter width; must satisfy 2^CTR_W > TIMEOUT_CYCLES.

Ports:
- g_clk in 1: clock.
- g_reset in 1: synchronous, active-high reset.
- id_valid in 1: decoded instruction valid.
- id_ready out 1: dispatch can accept an instruction.
- id_class in 4, id_subclass in 5, id_pw in 3, id_imm in 32: decoded fields.
- id_crd in 4, id_crs1 in 4, id_crs2 in 4, id_crs3 in 4: CPR indices.
- id_gpr_rs1 in 32: GPR operand.
- cpr_rs1_addr out 4, cpr_rs2_addr out 4, cpr_rs3_addr out 4: CPR read addresses.
- cpr_rs1_rdata in 32, cpr_rs2_rdata in 32, cpr_rs3_rdata in 32: CPR read data, combinational from addresses.
- palu_ivalid out 1, palu_idone in 1: PALU handshake.
- palu_rs1 out 32, palu_rs2 out 32, palu_rs3 out 32, palu_gpr_rs1 out 32: PALU operands.
- palu_class out 4, palu_subclass out 5, palu_pw out 3, palu_imm out 32: PALU instruction fields.
- palu_cpr_rd_ben in 4, palu_cpr_rd_wdata in 32: PALU result.
- cpr_rd_addr out 4, cpr_rd_ben out 4, cpr_rd_wdata out 32: CPR write port.
- insn_done out 1: one-cycle completion pulse.
- insn_error out 1: one-cycle watchdog abort pulse; tied 0 without the macro.

Behaviour:
- Clock and reset: single clock domain, g_clk. g_reset is synchronous and active-high.
- Reset values: state=IDLE; all registered fields 0; palu_ivalid=0; cpr_rd_ben=0; insn_done=0; insn_error=0; id_ready=1 on the first cycle after reset.
- IDLE:
  - id_ready=1.
  - On id_valid&&id_ready, latch class, subclass, pw, imm, crd, crs1-3 and gpr_rs1, then go to READ.
- READ:
  - Drive cpr_rsN_addr from the latched indices (the addresses are driven from latched indices in all states).
  - Register cpr_rsN_rdata into the operand registers, then go to EXEC.
- EXEC:
  - palu_ivalid=1; all palu_* outputs come from registers and stay constant for the whole of EXEC.
  - On palu_idone=1, capture palu_cpr_rd_ben and palu_cpr_rd_wdata, then go to WB.
  - Multi-cycle multiplies keep the FSM in EXEC with palu_ivalid held.
- WB:
  - cpr_rd_addr=crd, cpr_rd_ben=captured ben, cpr_rd_wdata=captured data, all for exactly one cycle.
  - insn_done=1 in the same cycle; then go to IDLE.
  - A ben of 0 (e.g. failed CMOV) still completes with insn_done=1 and writes no bytes.
- Latency:
  - Accept at cycle T; READ at T+1; EXEC at T+2.
  - Single-cycle op: WB/insn_done at T+3; next accept no earlier than T+4.
  - Throughput is one instruction per 4 cycles minimum.
- Hazards: no forwarding is needed, because READ of instruction n+1 follows the WB of instruction n.
- palu_ivalid is 0 in every state other than EXEC. palu_idone is ignored outside EXEC.
- cpr_rd_ben is 0 in every state other than WB.
- Reset asserted in any state: next state IDLE; no CPR write; no insn_done.

Optional Feature:
- SCARV_COP_DISPATCH_WDOG_EN defined:
  - The counter clears on entry to EXEC and increments each EXEC cycle without palu_idone.
  - When the count reaches TIMEOUT_CYCLES, drop palu_ivalid, pulse insn_error for one cycle, return to IDLE, and perform no CPR write and no insn_done.
  - idone arriving in the same cycle as the timeout wins: normal WB.
- Undefined: no counter logic; insn_error=0; EXEC waits indefinitely.

Decomposition:
- Shared package/header:
  - FSM state encoding (IDLE=2'd0, READ=2'd1, EXEC=2'd2, WB=2'd3).
  - CPR index width.
  - The class/subclass constants already in the common header; reuse them, do not redefine.
- One sub-module is natural: scarv_cop_dispatch_wdog, which takes clear/enable inputs and produces the timeout output; it is instantiated only under the macro.

Test Plan:
1. PADD, pw=32, CPR[1]=0x00000005, CPR[2]=0x00000003, crd=4, PALU model with idone=ivalid returning ben=F and data 0x8 → cpr_rd_addr=4, ben=F, wdata=0x00000008, insn_done exactly at T+3; id_ready low during T+1..T+3.
2. PMUL model asserting idone after 5 EXEC cycles → palu_ivalid high for exactly 5 cycles; palu_rs1/rs2/imm unchanged throughout; single WB afterwards.
3. CMOV_T with returned ben=0 → insn_done=1; cpr_rd_ben=0; CPR contents unchanged.
4. Back-to-back: instruction A writes CPR[3]=0xDEADBEEF, then B reads crs1=3 → B's palu_rs1=0xDEADBEEF (no stale read).
5. g_reset asserted during EXEC → next cycle palu_ivalid=0, id_ready=1; no cpr_rd_ben and no insn_done pulse.
6. With WDOG_EN and TIMEOUT_CYCLES=8, PALU never asserts idone → insn_error pulses once after 8 EXEC cycles; cpr_rd_ben stays 0; accept resumes. Second run with idone on cycle 8 → normal WB and no error.

Source files
------------

// File: rtl/scarv_cop_palu_dispatch_pkg.sv
// Shared types for the packed-ALU dispatch controller: FSM state encoding,
// CPR index width and the latched instruction field bundle. Class and
// subclass encodings live in the common coprocessor header; the dispatcher
// passes those fields through to the PALU without interpreting them.
package scarv_cop_palu_dispatch_pkg;

    localparam int CPR_IDX_W = 4;

    typedef logic [CPR_IDX_W-1:0] cpr_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } dispatch_state_t;

    typedef struct packed {
        logic [3:0]  insn_class;
        logic [4:0]  subclass;
        logic [2:0]  pw;
        logic [31:0] imm;
        logic [31:0] gpr_rs1;
    } insn_fields_t;

endpackage

// File: rtl/scarv_cop_palu_dispatch_if.sv
// Decode-side issue channel: valid/ready handshake plus the decoded
// instruction fields. The decoder is the master, the dispatcher the slave.
interface scarv_cop_palu_dispatch_if;
    import scarv_cop_palu_dispatch_pkg::*;

    logic        id_valid;
    logic        id_ready;
    logic [3:0]  id_class;
    logic [4:0]  id_subclass;
    logic [2:0]  id_pw;
    logic [31:0] id_imm;
    cpr_idx_t    id_crd;
    cpr_idx_t    id_crs1;
    cpr_idx_t    id_crs2;
    cpr_idx_t    id_crs3;
    logic [31:0] id_gpr_rs1;

    modport master (
        output id_valid, id_class, id_subclass, id_pw, id_imm,
               id_crd, id_crs1, id_crs2, id_crs3, id_gpr_rs1,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_class, id_subclass, id_pw, id_imm,
               id_crd, id_crs1, id_crs2, id_crs3, id_gpr_rs1,
        output id_ready
    );

endinterface

// File: rtl/scarv_cop_palu_dispatch_wdog.sv
// EXEC-phase watchdog: counts EXEC cycles that end without PALU completion
// and flags the cycle in which the count reaches TIMEOUT_CYCLES.
module scarv_cop_dispatch_wdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CTR_W          = 7
) (
    input  logic g_clk,
    input  logic g_reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    logic [CTR_W-1:0] count;

    // Count idle EXEC cycles; cleared on the way into EXEC.
    always_ff @(posedge g_clk) begin
        if (g_reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Fires in the cycle whose increment would make the count TIMEOUT_CYCLES.
    assign timeout = enable && (count == CTR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/scarv_cop_palu_dispatch.sv
// Issue/writeback controller for the packed ALU. Accepts one decoded
// instruction, reads its CPR operands, holds them to the PALU until idone,
// then commits the byte-enabled result and pulses insn_done.
// Optional watchdog: define SCARV_COP_DISPATCH_WDOG_EN.
module scarv_cop_palu_dispatch
    import scarv_cop_palu_dispatch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CTR_W          = 7
) (
    input  logic        g_clk,
    input  logic        g_reset,
    scarv_cop_palu_dispatch_if.slave id,
    output cpr_idx_t    cpr_rs1_addr,
    output cpr_idx_t    cpr_rs2_addr,
    output cpr_idx_t    cpr_rs3_addr,
    input  logic [31:0] cpr_rs1_rdata,
    input  logic [31:0] cpr_rs2_rdata,
    input  logic [31:0] cpr_rs3_rdata,
    output logic        palu_ivalid,
    input  logic        palu_idone,
    output logic [31:0] palu_rs1,
    output logic [31:0] palu_rs2,
    output logic [31:0] palu_rs3,
    output logic [31:0] palu_gpr_rs1,
    output logic [3:0]  palu_class,
    output logic [4:0]  palu_subclass,
    output logic [2:0]  palu_pw,
    output logic [31:0] palu_imm,
    input  logic [3:0]  palu_cpr_rd_ben,
    input  logic [31:0] palu_cpr_rd_wdata,
    output cpr_idx_t    cpr_rd_addr,
    output logic [3:0]  cpr_rd_ben,
    output logic [31:0] cpr_rd_wdata,
    output logic        insn_done,
    output logic        insn_error
);

    if (TIMEOUT_CYCLES < 1 || (2 ** CTR_W) <= TIMEOUT_CYCLES) begin : g_param_check
        $error("scarv_cop_palu_dispatch: CTR_W too narrow for TIMEOUT_CYCLES");
    end

    dispatch_state_t state;
    insn_fields_t    fields;
    cpr_idx_t        crd, crs1, crs2, crs3;
    logic [31:0]     opnd_rs1, opnd_rs2, opnd_rs3;
    logic [31:0]     res_wdata;
    logic [3:0]      res_ben;
    logic            ready, ivalid, done;

`ifdef SCARV_COP_DISPATCH_WDOG_EN
    logic timeout;
    logic error_pulse;

    scarv_cop_dispatch_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CTR_W          (CTR_W)
    ) u_wdog (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .clear   (state == READ),
        .enable  ((state == EXEC) && !palu_idone),
        .timeout (timeout)
    );

    assign insn_error = error_pulse;
`else
    assign insn_error = 1'b0;
`endif

    // Issue FSM; every handshake and write-port output is a register.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state    <= IDLE;
            fields   <= '0;
            crd      <= '0;
            crs1     <= '0;
            crs2     <= '0;
            crs3     <= '0;
            opnd_rs1 <= '0;
            opnd_rs2 <= '0;
            opnd_rs3 <= '0;
            res_wdata <= '0;
            res_ben  <= '0;
            ready    <= 1'b1;
            ivalid   <= 1'b0;
            done     <= 1'b0;
`ifdef SCARV_COP_DISPATCH_WDOG_EN
            error_pulse <= 1'b0;
`endif
        end else begin
            // Write enables and completion are single-cycle pulses.
            res_ben <= '0;
            done    <= 1'b0;
`ifdef SCARV_COP_DISPATCH_WDOG_EN
            error_pulse <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (id.id_valid && ready) begin
                        fields <= '{insn_class: id.id_class, subclass: id.id_subclass,
                                    pw: id.id_pw, imm: id.id_imm, gpr_rs1: id.id_gpr_rs1};
                        crd    <= id.id_crd;
                        crs1   <= id.id_crs1;
                        crs2   <= id.id_crs2;
                        crs3   <= id.id_crs3;
                        ready  <= 1'b0;
                        state  <= READ;
                    end
                end
                READ: begin
                    opnd_rs1 <= cpr_rs1_rdata;
                    opnd_rs2 <= cpr_rs2_rdata;
                    opnd_rs3 <= cpr_rs3_rdata;
                    ivalid   <= 1'b1;
                    state    <= EXEC;
                end
                EXEC: begin
                    if (palu_idone) begin
                        res_ben   <= palu_cpr_rd_ben;
                        res_wdata <= palu_cpr_rd_wdata;
                        ivalid    <= 1'b0;
                        done      <= 1'b1;
                        state     <= WB;
                    end
`ifdef SCARV_COP_DISPATCH_WDOG_EN
                    else if (timeout) begin
                        ivalid      <= 1'b0;
                        error_pulse <= 1'b1;
                        ready       <= 1'b1;
                        state       <= IDLE;
                    end
`endif
                end
                WB: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign id.id_ready     = ready;
    assign cpr_rs1_addr    = crs1;
    assign cpr_rs2_addr    = crs2;
    assign cpr_rs3_addr    = crs3;
    assign palu_ivalid     = ivalid;
    assign palu_rs1        = opnd_rs1;
    assign palu_rs2        = opnd_rs2;
    assign palu_rs3        = opnd_rs3;
    assign palu_gpr_rs1    = fields.gpr_rs1;
    assign palu_class      = fields.insn_class;
    assign palu_subclass   = fields.subclass;
    assign palu_pw         = fields.pw;
    assign palu_imm        = fields.imm;
    assign cpr_rd_addr     = crd;
    assign cpr_rd_ben      = res_ben;
    assign cpr_rd_wdata    = res_wdata;
    assign insn_done       = done;

endmodule

// File: tb/tb_scarv_cop_palu_dispatch.sv
// Bench for scarv_cop_palu_dispatch: CPR file and PALU models around the
// DUT, with a reference CPR image updated from the architectural rules.
module tb_scarv_cop_palu_dispatch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scarv_cop_palu_dispatch_if id_bus();

    logic [3:0]  cpr_rs1_addr, cpr_rs2_addr, cpr_rs3_addr, cpr_rd_addr;
    logic [31:0] cpr_rs1_rdata, cpr_rs2_rdata, cpr_rs3_rdata;
    logic        palu_ivalid, palu_idone;
    logic [31:0] palu_rs1, palu_rs2, palu_rs3, palu_gpr_rs1, palu_imm;
    logic [3:0]  palu_class;
    logic [4:0]  palu_subclass;
    logic [2:0]  palu_pw;
    logic [3:0]  palu_cpr_rd_ben, cpr_rd_ben;
    logic [31:0] palu_cpr_rd_wdata, cpr_rd_wdata;
    logic        insn_done, insn_error;

    scarv_cop_palu_dispatch #(.TIMEOUT_CYCLES(8), .CTR_W(4)) dut (
        .g_clk(clk), .g_reset(rst), .id(id_bus.slave),
        .cpr_rs1_addr(cpr_rs1_addr), .cpr_rs2_addr(cpr_rs2_addr), .cpr_rs3_addr(cpr_rs3_addr),
        .cpr_rs1_rdata(cpr_rs1_rdata), .cpr_rs2_rdata(cpr_rs2_rdata), .cpr_rs3_rdata(cpr_rs3_rdata),
        .palu_ivalid(palu_ivalid), .palu_idone(palu_idone),
        .palu_rs1(palu_rs1), .palu_rs2(palu_rs2), .palu_rs3(palu_rs3), .palu_gpr_rs1(palu_gpr_rs1),
        .palu_class(palu_class), .palu_subclass(palu_subclass), .palu_pw(palu_pw), .palu_imm(palu_imm),
        .palu_cpr_rd_ben(palu_cpr_rd_ben), .palu_cpr_rd_wdata(palu_cpr_rd_wdata),
        .cpr_rd_addr(cpr_rd_addr), .cpr_rd_ben(cpr_rd_ben), .cpr_rd_wdata(cpr_rd_wdata),
        .insn_done(insn_done), .insn_error(insn_error)
    );

    // CPR file environment: combinational reads, byte-enabled writes, preload port.
    logic [31:0] cpr [16];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_val;
    assign cpr_rs1_rdata = cpr[cpr_rs1_addr];
    assign cpr_rs2_rdata = cpr[cpr_rs2_addr];
    assign cpr_rs3_rdata = cpr[cpr_rs3_addr];
    always @(posedge clk) begin
        if (pl_en) cpr[pl_idx] <= pl_val;
        for (int b = 0; b < 4; b++)
            if (cpr_rd_ben[b]) cpr[cpr_rd_addr][8*b +: 8] <= cpr_rd_wdata[8*b +: 8];
    end

    // PALU model: answers idone after palu_lat EXEC cycles (never if palu_never).
    int          exec_cnt = 0;
    int          palu_lat;
    bit          palu_never;
    logic [3:0]  palu_ben;
    logic [31:0] palu_data;
    always @(posedge clk) exec_cnt <= palu_ivalid ? exec_cnt + 1 : 0;
    assign palu_idone        = palu_ivalid && !palu_never && (exec_cnt == palu_lat - 1);
    assign palu_cpr_rd_ben   = palu_ben;
    assign palu_cpr_rd_wdata = palu_data;

    logic [31:0] ref_cpr [16];
    int total = 0;
    int bad = 0;

    logic [31:0] cur_imm, cur_gpr;
    logic [3:0]  cur_class;
    int  obs_done_cyc, obs_err_cyc, obs_done_cnt, obs_err_cnt, obs_iv_cyc;
    bit  obs_stable, obs_leak, obs_ready_low, obs_ready_after, obs_finished;
    logic [3:0]  obs_ben, obs_addr, obs_class;
    logic [31:0] obs_wdata, obs_rs1, obs_rs2, obs_rs3, obs_gpr, obs_imm;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] ben,
                                          input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (ben[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = 4'(idx); pl_val = val;
        step();
        pl_en = 1'b0;
        ref_cpr[idx] = val;
    endtask

    // Present one instruction and hold it until accepted; returns at T+1.
    task automatic issue(input logic [3:0] crd, input logic [3:0] crs1, input logic [3:0] crs2,
                         input logic [3:0] crs3, output bit ok);
        bit rdy;
        cur_imm = $urandom; cur_gpr = $urandom; cur_class = 4'($urandom);
        id_bus.id_class = cur_class; id_bus.id_subclass = 5'($urandom); id_bus.id_pw = 3'($urandom);
        id_bus.id_imm = cur_imm; id_bus.id_gpr_rs1 = cur_gpr;
        id_bus.id_crd = crd; id_bus.id_crs1 = crs1; id_bus.id_crs2 = crs2; id_bus.id_crs3 = crs3;
        id_bus.id_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rdy = id_bus.id_ready;
            step();
            if (rdy) begin ok = 1'b1; break; end
        end
        id_bus.id_valid = 1'b0;
    endtask

    // Record what the DUT does from T+1 until one cycle past done/error.
    task automatic observe(input int budget);
        obs_done_cyc = -1; obs_err_cyc = -1; obs_done_cnt = 0; obs_err_cnt = 0; obs_iv_cyc = 0;
        obs_stable = 1; obs_leak = 0; obs_ready_low = 1; obs_ready_after = 0; obs_finished = 0;
        for (int k = 1; k <= budget; k++) begin
            if (palu_ivalid) begin
                if (obs_iv_cyc == 0) begin
                    obs_rs1 = palu_rs1; obs_rs2 = palu_rs2; obs_rs3 = palu_rs3;
                    obs_gpr = palu_gpr_rs1; obs_imm = palu_imm; obs_class = palu_class;
                end else if (palu_rs1 !== obs_rs1 || palu_rs2 !== obs_rs2 || palu_rs3 !== obs_rs3 ||
                             palu_gpr_rs1 !== obs_gpr || palu_imm !== obs_imm || palu_class !== obs_class)
                    obs_stable = 0;
                obs_iv_cyc++;
            end
            if (cpr_rd_ben !== 4'h0 && !insn_done) obs_leak = 1;
            if (insn_error) begin obs_err_cnt++; if (obs_err_cyc < 0) obs_err_cyc = k; end
            if (obs_done_cyc < 0 && obs_err_cyc < 0 && id_bus.id_ready) obs_ready_low = 0;
            if (insn_done) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc = k; obs_ben = cpr_rd_ben; obs_addr = cpr_rd_addr; obs_wdata = cpr_rd_wdata;
                end
            end
            if ((obs_done_cyc > 0 && k == obs_done_cyc + 1) || (obs_err_cyc > 0 && k == obs_err_cyc + 1)) begin
                obs_ready_after = id_bus.id_ready;
                obs_finished = 1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        total++; if (id_bus.id_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", id_bus.id_ready); end
        total++; if (palu_ivalid !== 1'b0) begin bad++; $display("FAIL rst_ivalid got=%b exp=0", palu_ivalid); end
        total++; if (cpr_rd_ben !== 4'h0) begin bad++; $display("FAIL rst_ben got=%h exp=0", cpr_rd_ben); end
        total++; if (insn_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", insn_done); end
        total++; if (insn_error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b exp=0", insn_error); end
        total++; if (cpr_rd_addr !== 4'h0 || cpr_rs1_addr !== 4'h0 || palu_imm !== 32'h0) begin
            bad++; $display("FAIL rst_fields got=%h/%h/%h exp=0", cpr_rd_addr, cpr_rs1_addr, palu_imm); end
    endtask

    task automatic test_padd();
        bit ok;
        preload(1, 32'h5); preload(2, 32'h3);
        palu_lat = 1; palu_ben = 4'hF; palu_data = ref_cpr[1] + ref_cpr[2];
        issue(4'd4, 4'd1, 4'd2, 4'd0, ok);
        observe(20);
        total++; if (!ok || !obs_finished) begin bad++; $display("FAIL padd_complete got=%b%b exp=11", ok, obs_finished); end
        total++; if (obs_done_cyc !== 3) begin bad++; $display("FAIL padd_done_cyc got=%0d exp=3", obs_done_cyc); end
        total++; if (obs_addr !== 4'd4 || obs_ben !== 4'hF) begin bad++; $display("FAIL padd_wport got=%h/%h exp=4/f", obs_addr, obs_ben); end
        total++; if (obs_wdata !== 32'h8) begin bad++; $display("FAIL padd_wdata got=%h exp=00000008", obs_wdata); end
        total++; if (obs_rs1 !== 32'h5 || obs_rs2 !== 32'h3) begin bad++; $display("FAIL padd_opnd got=%h/%h exp=5/3", obs_rs1, obs_rs2); end
        total++; if (!obs_ready_low || !obs_ready_after) begin bad++; $display("FAIL padd_ready got=%b%b exp=11", obs_ready_low, obs_ready_after); end
        total++; if (obs_iv_cyc !== 1) begin bad++; $display("FAIL padd_iv_cycles got=%0d exp=1", obs_iv_cyc); end
        ref_cpr[4] = merge(ref_cpr[4], 4'hF, palu_data);
    endtask

    task automatic test_pmul();
        bit ok;
        preload(5, $urandom); preload(6, $urandom);
        palu_lat = 5; palu_ben = 4'hF; palu_data = ref_cpr[5] * ref_cpr[6];
        issue(4'd8, 4'd5, 4'd6, 4'd2, ok);
        observe(30);
        total++; if (!ok || !obs_finished) begin bad++; $display("FAIL pmul_complete got=%b%b exp=11", ok, obs_finished); end
        total++; if (obs_iv_cyc !== 5) begin bad++; $display("FAIL pmul_iv_cycles got=%0d exp=5", obs_iv_cyc); end
        total++; if (!obs_stable) begin bad++; $display("FAIL pmul_stable got=0 exp=1"); end
        total++; if (obs_done_cnt !== 1 || obs_done_cyc !== 7) begin bad++; $display("FAIL pmul_done got=%0d@%0d exp=1@7", obs_done_cnt, obs_done_cyc); end
        total++; if (obs_rs1 !== ref_cpr[5] || obs_imm !== cur_imm) begin bad++; $display("FAIL pmul_opnd got=%h/%h exp=%h/%h", obs_rs1, obs_imm, ref_cpr[5], cur_imm); end
        total++; if (obs_wdata !== palu_data) begin bad++; $display("FAIL pmul_wdata got=%h exp=%h", obs_wdata, palu_data); end
        ref_cpr[8] = merge(ref_cpr[8], 4'hF, palu_data);
    endtask

    task automatic test_cmov_zero_ben();
        bit ok;
        palu_lat = 1; palu_ben = 4'h0; palu_data = $urandom;
        issue(4'd7, 4'd1, 4'd2, 4'd3, ok);
        observe(20);
        total++; if (!ok || obs_done_cnt !== 1) begin bad++; $display("FAIL cmov_done got=%b/%0d exp=1/1", ok, obs_done_cnt); end
        total++; if (obs_ben !== 4'h0 || obs_leak) begin bad++; $display("FAIL cmov_ben got=%h leak=%b exp=0", obs_ben, obs_leak); end
        total++; if (cpr[7] !== ref_cpr[7]) begin bad++; $display("FAIL cmov_cpr got=%h exp=%h", cpr[7], ref_cpr[7]); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        palu_lat = 1; palu_ben = 4'hF; palu_data = 32'hDEADBEEF;
        issue(4'd3, 4'd0, 4'd1, 4'd2, ok);
        observe(20);
        ref_cpr[3] = merge(ref_cpr[3], 4'hF, 32'hDEADBEEF);
        palu_data = 32'h0BADF00D;
        issue(4'd10, 4'd3, 4'd3, 4'd1, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_accept got=0 exp=1"); end
        observe(20);
        total++; if (obs_rs1 !== 32'hDEADBEEF || obs_rs2 !== 32'hDEADBEEF) begin
            bad++; $display("FAIL b2b_fresh_read got=%h/%h exp=deadbeef", obs_rs1, obs_rs2); end
        total++; if (obs_done_cyc !== 3) begin bad++; $display("FAIL b2b_done_cyc got=%0d exp=3", obs_done_cyc); end
        ref_cpr[10] = merge(ref_cpr[10], 4'hF, 32'h0BADF00D);
    endtask

    task automatic test_random();
        bit ok;
        logic [3:0] crd, s1, s2, s3;
        logic [31:0] e1, e2, e3;
        for (int n = 0; n < 24; n++) begin
            crd = 4'($urandom); s1 = 4'($urandom); s2 = 4'($urandom); s3 = 4'($urandom);
            e1 = ref_cpr[s1]; e2 = ref_cpr[s2]; e3 = ref_cpr[s3];
            palu_lat = $urandom_range(1, 6); palu_ben = 4'($urandom); palu_data = $urandom;
            issue(crd, s1, s2, s3, ok);
            observe(40);
            total++; if (!ok || !obs_finished) begin bad++; $display("FAIL rnd%0d_complete got=%b%b exp=11", n, ok, obs_finished); end
            total++; if (obs_done_cyc !== 2 + palu_lat || obs_done_cnt !== 1) begin
                bad++; $display("FAIL rnd%0d_done got=%0d@%0d exp=1@%0d", n, obs_done_cnt, obs_done_cyc, 2 + palu_lat); end
            total++; if (obs_iv_cyc !== palu_lat || !obs_stable) begin
                bad++; $display("FAIL rnd%0d_exec got=%0d stable=%b exp=%0d", n, obs_iv_cyc, obs_stable, palu_lat); end
            total++; if (obs_rs1 !== e1 || obs_rs2 !== e2 || obs_rs3 !== e3) begin
                bad++; $display("FAIL rnd%0d_opnd got=%h/%h/%h exp=%h/%h/%h", n, obs_rs1, obs_rs2, obs_rs3, e1, e2, e3); end
            total++; if (obs_gpr !== cur_gpr || obs_imm !== cur_imm || obs_class !== cur_class) begin
                bad++; $display("FAIL rnd%0d_fields got=%h/%h/%h exp=%h/%h/%h", n, obs_gpr, obs_imm, obs_class, cur_gpr, cur_imm, cur_class); end
            total++; if (obs_addr !== crd || obs_ben !== palu_ben || obs_wdata !== palu_data || obs_leak) begin
                bad++; $display("FAIL rnd%0d_wport got=%h/%h/%h exp=%h/%h/%h", n, obs_addr, obs_ben, obs_wdata, crd, palu_ben, palu_data); end
            total++; if (!obs_ready_low || !obs_ready_after) begin
                bad++; $display("FAIL rnd%0d_ready got=%b%b exp=11", n, obs_ready_low, obs_ready_after); end
            ref_cpr[crd] = merge(ref_cpr[crd], palu_ben, palu_data);
        end
    endtask

    task automatic test_reset_in_exec();
        bit ok, seen;
        palu_never = 1'b1;
        issue(4'd11, 4'd1, 4'd2, 4'd3, ok);
        step();
        total++; if (!ok || palu_ivalid !== 1'b1) begin bad++; $display("FAIL rexec_in_exec got=%b%b exp=11", ok, palu_ivalid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (palu_ivalid !== 1'b0 || id_bus.id_ready !== 1'b1) begin
            bad++; $display("FAIL rexec_state got=%b/%b exp=0/1", palu_ivalid, id_bus.id_ready); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (insn_done || cpr_rd_ben !== 4'h0 || insn_error) seen = 1;
            step();
        end
        total++; if (seen) begin bad++; $display("FAIL rexec_no_commit got=1 exp=0"); end
        palu_never = 1'b0;
    endtask

`ifdef SCARV_COP_DISPATCH_WDOG_EN
    task automatic test_wdog();
        bit ok;
        palu_never = 1'b1; palu_lat = 1; palu_ben = 4'hF; palu_data = $urandom;
        issue(4'd9, 4'd1, 4'd2, 4'd3, ok);
        observe(40);
        total++; if (!ok || !obs_finished) begin bad++; $display("FAIL wdog_end got=%b%b exp=11", ok, obs_finished); end
        total++; if (obs_err_cnt !== 1 || obs_err_cyc !== 10) begin bad++; $display("FAIL wdog_error got=%0d@%0d exp=1@10", obs_err_cnt, obs_err_cyc); end
        total++; if (obs_iv_cyc !== 8) begin bad++; $display("FAIL wdog_iv_cycles got=%0d exp=8", obs_iv_cyc); end
        total++; if (obs_done_cnt !== 0 || obs_leak || cpr[9] !== ref_cpr[9]) begin
            bad++; $display("FAIL wdog_no_commit got=%0d/%b/%h exp=0/0/%h", obs_done_cnt, obs_leak, cpr[9], ref_cpr[9]); end
        total++; if (!obs_ready_after) begin bad++; $display("FAIL wdog_ready got=0 exp=1"); end
        palu_never = 1'b0; palu_lat = 8;
        issue(4'd9, 4'd4, 4'd5, 4'd6, ok);
        observe(40);
        total++; if (!ok || obs_done_cyc !== 10 || obs_err_cnt !== 0) begin
            bad++; $display("FAIL wdog_late_idone got=%b/%0d/%0d exp=1/10/0", ok, obs_done_cyc, obs_err_cnt); end
        ref_cpr[9] = merge(ref_cpr[9], 4'hF, palu_data);
    endtask
`endif

    task automatic test_cpr_image();
        for (int i = 0; i < 16; i++) begin
            total++; if (cpr[i] !== ref_cpr[i]) begin bad++; $display("FAIL cpr_image[%0d] got=%h exp=%h", i, cpr[i], ref_cpr[i]); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL sim_time_limit got=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        palu_lat = 1; palu_never = 1'b0; palu_ben = '0; palu_data = '0;
        id_bus.id_valid = 1'b0; id_bus.id_class = '0; id_bus.id_subclass = '0; id_bus.id_pw = '0;
        id_bus.id_imm = '0; id_bus.id_crd = '0; id_bus.id_crs1 = '0; id_bus.id_crs2 = '0;
        id_bus.id_crs3 = '0; id_bus.id_gpr_rs1 = '0;
        test_reset();
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        test_padd();
        test_pmul();
        test_cmov_zero_ben();
        test_back_to_back();
        test_random();
        test_reset_in_exec();
`ifdef SCARV_COP_DISPATCH_WDOG_EN
        test_wdog();
`endif
        test_cpr_image();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
